// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on input and output.
// Optional accumulator chaining (acc_sel input) is enabled by defining ALU_PIPE_ACC_EN.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
`ifdef ALU_PIPE_ACC_EN
  input  logic             acc_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_XNOR = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s2_valid;
  logic             advance;
  logic             accept;

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             v_d;

  assign advance   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || advance;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

`ifdef ALU_PIPE_ACC_EN
  logic             s1_acc;
  logic [WIDTH-1:0] acc_q;

  // Last result that left S2; cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (s2_valid && out_ready) begin
      acc_q <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_acc <= acc_sel;
    end
  end

  // Operand substitution is resolved in S1: any older in-flight op can only
  // sit in S2 by then, so S2 (if valid) is the youngest result, else acc_q.
  always_comb begin
    a_eff = s1_a;
    if (s1_acc) begin
      a_eff = s2_valid ? result : acc_q;
    end
  end
`else
  assign a_eff = s1_a;
`endif

  // Stage 1: operand capture. Only the valid bit needs reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a  <= a;
      s1_b  <= b;
      s1_op <= op_e'(op);
    end
  end

  always_comb begin
    sum   = {1'b0, a_eff} + {1'b0, s1_b};
    diff  = {1'b0, a_eff} - {1'b0, s1_b};
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (a_eff[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff[WIDTH-1:0];
        c_d   = diff[WIDTH];
        v_d   = (a_eff[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_AND:  res_d = a_eff & s1_b;
      OP_OR:   res_d = a_eff | s1_b;
      OP_XOR:  res_d = a_eff ^ s1_b;
      OP_NAND: res_d = ~(a_eff & s1_b);
      OP_NOR:  res_d = ~(a_eff | s1_b);
      OP_XNOR: res_d = ~(a_eff ^ s1_b);
      default: res_d = '0;
    endcase
  end

  // Stage 2: result and flags, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_d;
        flag_z <= (res_d == '0);
        flag_n <= res_d[WIDTH-1];
        flag_c <= c_d;
        flag_v <= v_d;
      end
    end
  end

endmodule
